// File: rtl/wb_pkg.sv
// Shared widths, FSM state encoding and request payload type for the
// register-file writeback arbiter.
package wb_pkg;

    localparam int REG_AW = 4;
    localparam int DATA_W = 32;

    typedef enum logic {
        EX_PRI = 1'b0,
        LD_PRI = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback bus: execute and load-return request channels plus the
// registered register-file write port.
interface wb_port_arbiter_if;
    import wb_pkg::*;

    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_data;
    logic              ex_ready;

    logic              ld_valid;
    logic [REG_AW-1:0] ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;

    logic              rf_we;
    logic [REG_AW-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;

    // Requester / register-file side.
    modport master (
        output ex_valid, ex_rd, ex_data,
        input  ex_ready,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        input  rf_we, rf_wa, rf_wd
    );

    // Arbiter side.
    modport slave (
        input  ex_valid, ex_rd, ex_data,
        output ex_ready,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        output rf_we, rf_wa, rf_wd
    );

endinterface

// File: rtl/wb_ld_fifo.sv
// In-order load-return buffer; head is the oldest entry, valid whenever
// empty is low. Pointers wrap naturally because DEPTH is a power of two.
module wb_ld_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  wb_req_t                  din,
    output wb_req_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage has no reset; an entry is only read after it was written,
    // so clearing it would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by execute results and buffered
// load returns; execute normally wins, loads are forced through when the
// buffer fills or its head has waited too long.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int LD_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    wb_port_arbiter_if.slave        bus
);

    localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX - 1);
    localparam int CW = $clog2(LD_DEPTH) + 1;

    arb_state_e       state;
    arb_state_e       state_nx;
    logic [SW-1:0]    starve;
    logic             sel_ex;
    logic             sel_ld;
    logic             ex_ready;
    logic             ld_push;
    wb_req_t          ld_in;
    wb_req_t          ld_head;
    logic             ld_full;
    logic             ld_empty;
    logic [CW-1:0]    ld_count;

    assign ld_in   = '{rd: bus.ld_rd, data: bus.ld_data};
    assign ld_push = bus.ld_valid && !ld_full;

    wb_ld_fifo #(.DEPTH(LD_DEPTH)) u_ld_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ld_push),
        .pop   (sel_ld),
        .din   (ld_in),
        .head  (ld_head),
        .full  (ld_full),
        .empty (ld_empty),
        .count (ld_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EX_PRI;
        else     state <= state_nx;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        ex_ready = 1'b0;
        sel_ex   = 1'b0;
        sel_ld   = 1'b0;
        case (state)
            EX_PRI: begin
                ex_ready = 1'b1;
                if (bus.ex_valid)   sel_ex = 1'b1;
                else if (!ld_empty) sel_ld = 1'b1;
                if (ld_full || (starve == STARVE_LIM && !ld_empty && !sel_ld))
                    state_nx = LD_PRI;
            end
            LD_PRI: begin
                sel_ld = !ld_empty;
                // Drop back once the final buffered load leaves with nothing behind it.
                if (ld_empty || (ld_count == CW'(1) && !ld_push))
                    state_nx = EX_PRI;
            end
            default: state_nx = EX_PRI;
        endcase
    end

    assign bus.ex_ready = ex_ready;
    assign bus.ld_ready = !ld_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve <= '0;
        end else if (ld_empty || sel_ld) begin
            starve <= '0;
        end else if (starve != STARVE_LIM) begin
            starve <= starve + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rf_we <= 1'b0;
            bus.rf_wa <= '0;
            bus.rf_wd <= '0;
        end else begin
            bus.rf_we <= sel_ex || sel_ld;
            if (sel_ex) begin
                bus.rf_wa <= bus.ex_rd;
                bus.rf_wd <= bus.ex_data;
            end else if (sel_ld) begin
                bus.rf_wa <= ld_head.rd;
                bus.rf_wd <= ld_head.data;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts
// each register-file write; an independent monitor checks what the DUT emits.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    localparam int LD_DEPTH   = 2;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(.LD_DEPTH(LD_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int          due;
        logic [3:0]  wa;
        logic [31:0] wd;
    } exp_t;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
    } ld_t;

    exp_t exp_q[$];
    ld_t  m_q[$];
    bit   m_ldpri = 1'b0;
    int   m_wait  = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
    endtask

    // One cycle of stimulus; the model decides from the rules what gets written
    // and queues it for the monitor one cycle later.
    task automatic step(input bit ev, input logic [3:0] erd, input logic [31:0] ed,
                        input bit lv, input logic [3:0] lrd, input logic [31:0] lda);
        bit exp_ex_ready;
        bit exp_ld_ready;
        bit popped;
        bit pushed;
        int n;
        @(negedge clk);
        #1;
        bus.ex_valid = ev;  bus.ex_rd = erd; bus.ex_data = ed;
        bus.ld_valid = lv;  bus.ld_rd = lrd; bus.ld_data = lda;
        #1;
        n            = m_q.size();
        exp_ex_ready = !m_ldpri;
        exp_ld_ready = (n < LD_DEPTH);
        check("ex_ready", 32'(bus.ex_ready), 32'(exp_ex_ready));
        check("ld_ready", 32'(bus.ld_ready), 32'(exp_ld_ready));
        popped = 1'b0;
        pushed = 1'b0;
        if (!m_ldpri && ev) begin
            exp_q.push_back(exp_t'{cyc + 1, erd, ed});
        end else if (n > 0) begin
            exp_q.push_back(exp_t'{cyc + 1, m_q[0].rd, m_q[0].data});
            void'(m_q.pop_front());
            popped = 1'b1;
        end
        if (lv && exp_ld_ready) begin
            m_q.push_back(ld_t'{lrd, lda});
            pushed = 1'b1;
        end
        if (!m_ldpri) begin
            if (n == LD_DEPTH || (m_wait == STARVE_MAX - 1 && n > 0 && !popped)) m_ldpri = 1'b1;
        end else if (n == 0 || (popped && n == 1 && !pushed)) begin
            m_ldpri = 1'b0;
        end
        if (n == 0 || popped)          m_wait = 0;
        else if (m_wait < STARVE_MAX - 1) m_wait = m_wait + 1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        bus.ex_valid = 1'b0;
        bus.ld_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("rst_rf_wa", 32'(bus.rf_wa), 32'd0);
        check("rst_rf_wd", bus.rf_wd, 32'd0);
        check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
        exp_q.delete();
        m_q.delete();
        m_ldpri = 1'b0;
        m_wait  = 0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every write the DUT presents must be the next predicted one,
    // in the predicted cycle; predicted writes that never appear are flagged.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rf_we) begin
                if (exp_q.size() == 0) begin
                    check("spurious_write", 32'(bus.rf_we), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_cycle", 32'(cyc), 32'(mon_e.due));
                    check("rf_wa", 32'(bus.rf_wa), 32'(mon_e.wa));
                    check("rf_wd", bus.rf_wd, mon_e.wd);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                mon_e = exp_q.pop_front();
                check("missed_write", 32'(bus.rf_we), 32'd1);
            end
        end
    end

    initial begin
        bus.ex_valid = 1'b0; bus.ex_rd = '0; bus.ex_data = '0;
        bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;
        repeat (2) @(negedge clk);
        check("init_rf_we", 32'(bus.rf_we), 32'd0);
        check("init_rf_wa", 32'(bus.rf_wa), 32'd0);
        check("init_rf_wd", bus.rf_wd, 32'd0);
        check("init_ex_ready", 32'(bus.ex_ready), 32'd1);
        check("init_ld_ready", 32'(bus.ld_ready), 32'd1);
        #1;
        rst = 1'b0;

        // Execute write, one-cycle latency.
        step(1'b1, 4'd3, 32'h0000_00AA, 1'b0, 4'd0, 32'd0);
        idle(2);

        // Load to empty buffer, written two cycles after acceptance.
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h0000_1234);
        idle(3);

        // Continuous execute traffic while buffer fills.
        step(1'b1, 4'd1, 32'h11, 1'b1, 4'd7, 32'h77);
        step(1'b1, 4'd2, 32'h22, 1'b1, 4'd8, 32'h88);
        for (int i = 0; i < 6; i++) step(1'b1, 4'(i), 32'h100 + 32'(i), 1'b0, 4'd0, 32'd0);
        idle(2);

        // Single buffered load starved by execute traffic.
        step(1'b1, 4'd4, 32'h44, 1'b1, 4'd9, 32'h99);
        for (int i = 0; i < 7; i++) step(1'b1, 4'(i + 8), 32'h200 + 32'(i), 1'b0, 4'd0, 32'd0);
        idle(2);

        // Full buffer popping while a new load is offered.
        step(1'b1, 4'd1, 32'h31, 1'b1, 4'd10, 32'hA0);
        step(1'b1, 4'd2, 32'h32, 1'b1, 4'd11, 32'hB0);
        step(1'b0, 4'd0, 32'd0,  1'b1, 4'd12, 32'hC0);
        step(1'b0, 4'd0, 32'd0,  1'b1, 4'd13, 32'hD0);
        idle(4);

        // Reset with two loads buffered: they must never be written.
        step(1'b1, 4'd6, 32'h66, 1'b1, 4'd14, 32'hE0);
        step(1'b1, 4'd6, 32'h67, 1'b1, 4'd15, 32'hF0);
        apply_reset();
        idle(6);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), 4'($urandom), $urandom,
                 ($urandom_range(0, 1) == 1), 4'($urandom), $urandom);
        end
        idle(8);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter LD_DEPTH, default 2: load-return buffer entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_MAX, default 4: max consecutive cycles a buffered load may wait before forced service.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ex_valid  input  1  execute-stage writeback request (ALU or call result).
REQ-006 ex_rd  input  4  execute-stage destination register.
REQ-007 ex_data  input  32  execute-stage write data.
REQ-008 ex_ready  output  1  execute request accepted this cycle when ex_valid && ex_ready.
REQ-009 ld_valid  input  1  load-return request from memory side.
REQ-010 ld_rd  input  4  load destination register.
REQ-011 ld_data  input  32  load data.
REQ-012 ld_ready  output  1  buffer not full; load enqueued when ld_valid && ld_ready.
REQ-013 rf_we  output  1  register-file write enable, registered.
REQ-014 rf_wa  output  4  register-file write address, registered.
REQ-015 rf_wd  output  32  register-file write data, registered.

Function
REQ-016 SHALL own the single register-file write port; at most one write per cycle.
REQ-017 SHALL buffer accepted loads in order in a LD_DEPTH-entry FIFO; ld_ready = !full, combinational on registered state only.
REQ-018 SHALL implement FSM states EX_PRI and LD_PRI; reset state EX_PRI.
REQ-019 EX_PRI: ex_ready=1; if ex_valid, write EX; else if FIFO non-empty, write FIFO head.
REQ-020 LD_PRI: ex_ready=0; write FIFO head every cycle.
REQ-021 EX_PRI->LD_PRI when FIFO full, or starve counter == STARVE_MAX-1 with FIFO non-empty and head not dequeued.
REQ-022 LD_PRI->EX_PRI on the cycle the last FIFO entry dequeues with no simultaneous enqueue.
REQ-023 Starve counter: increments each cycle FIFO non-empty and head not dequeued; clears on any dequeue or when FIFO empty; saturates at STARVE_MAX-1.
REQ-024 Write latency: selected request appears on rf_we/rf_wa/rf_wd exactly one cycle after selection; rf_we=0 in cycles with no selection.
REQ-025 Enqueue and dequeue in the same cycle SHALL both occur; occupancy unchanged.
REQ-026 Load arriving to empty FIFO SHALL NOT bypass the buffer; earliest write is 2 cycles after acceptance.
REQ-027 FIFO pointers SHALL wrap modulo LD_DEPTH; occupancy counter width clog2(LD_DEPTH)+1.
REQ-028 No register renaming or ordering check between EX and load streams; hazard avoidance belongs to the issue stage.

Reset
REQ-029 On rst high, asynchronously: state=EX_PRI, FIFO empty, pointers/counters 0, rf_we=0, rf_wa=0, rf_wd=0.
REQ-030 Reset mid-operation SHALL discard buffered loads; ld_ready=1 and ex_ready=1 in the first cycle after release.

Structure
REQ-031 Shared package wb_pkg SHALL hold REG_AW=4, DATA_W=32 and the FSM state enum.
REQ-032 FIFO SHALL be sub-module wb_ld_fifo (push/pop/full/empty/head); arbiter FSM, starve counter and output register in top.

Verification
REQ-033 Reset then ex_valid=1, ex_rd=3, ex_data=0x0000_00AA -> next cycle rf_we=1, rf_wa=3, rf_wd=0xAA.
REQ-034 Load rd=5 data=0x1234 with ex_valid idle -> rf_we=1, rf_wa=5, rf_wd=0x1234 two cycles after acceptance.
REQ-035 ex_valid held 1 continuously, two loads enqueued -> FIFO full, LD_PRI entered, ex_ready=0 for 2 cycles, loads written in order, then ex_ready=1.
REQ-036 ex_valid held 1, one load buffered -> forced load write after 4 waiting cycles (STARVE_MAX=4), ex_ready=0 that cycle.
REQ-037 FIFO full with one entry popping, new load offered -> ld_ready=0, no enqueue; next cycle ld_ready=1.
REQ-038 rst asserted with 2 loads buffered -> rf_we=0 immediately, no buffered load ever written, ld_ready=1 after release.
